// File: rtl/main_mem_ctrl.sv
// rtl/main_mem_ctrl.sv - fixed-latency word-read / line-write main memory model
module main_mem_ctrl #(
  parameter int LATENCY     = 4,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [31:0] resp_data,
  output logic        resp_ready,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic [1:0]     op_q;
  logic [AW-1:0]  idx_q;
  logic [63:0]    wdata_q;
  logic [31:0]    mem [DEPTH_WORDS];
  logic           accept;
  logic [AW-1:0]  idx_lo, idx_hi;
  logic           unused;

  assign accept = (state == IDLE) && req_valid && (req_op == OP_READ || req_op == OP_WRITE);
  assign idx_lo = idx_q & ~AW'(1);
  assign idx_hi = idx_q | AW'(1);
  assign unused = ^{req_addr[31:AW+2], req_addr[1:0]};

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    busy       = 1'b0;
    resp_ready = 1'b0;
    resp_data  = 32'h0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt   = CNT_LOAD;
          state_nxt = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        busy = 1'b1;
        // The counter holds the remaining WAIT cycles; the last one hands over to RESP.
        if (cnt <= 4'd1) begin
          cnt_nxt   = 4'd0;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        busy       = 1'b1;
        resp_ready = 1'b1;
        if (op_q == OP_READ) resp_data = mem[idx_q];
        cnt_nxt   = 4'd0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      op_q    <= req_op;
      idx_q   <= req_addr[AW+1:2];
      wdata_q <= req_wdata;
    end
  end

  // Storage is never reset; a write only lands if the RESP edge is reached.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && op_q == OP_WRITE) begin
      mem[idx_lo] <= wdata_q[31:0];
      mem[idx_hi] <= wdata_q[63:32];
    end
  end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb/tb_main_mem_ctrl.sv - randomized self-checking bench for main_mem_ctrl
module tb_main_mem_ctrl;

  localparam int LAT   = 4;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [31:0] resp_data;
  logic        resp_ready;
  logic        busy;

  logic        req_valid1;
  logic [1:0]  req_op1;
  logic [31:0] req_addr1;
  logic [63:0] req_wdata1;
  logic [31:0] resp_data1;
  logic        resp_ready1;
  logic        busy1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] model [DEPTH];

  main_mem_ctrl #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_data(resp_data),
    .resp_ready(resp_ready), .busy(busy)
  );

  main_mem_ctrl #(.LATENCY(1), .DEPTH_WORDS(16)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_op(req_op1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .resp_data(resp_data1),
    .resp_ready(resp_ready1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int widx(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] model_expect(input logic [1:0] op, input logic [31:0] addr);
    return (op == 2'b10) ? model[widx(addr)] : 32'h0;
  endfunction

  task automatic model_apply(input logic [1:0] op, input logic [31:0] addr, input logic [63:0] wd);
    int base;
    base = widx(addr) - (widx(addr) % 2);
    if (op == 2'b01) begin
      model[base]     = wd[31:0];
      model[base + 1] = wd[63:32];
    end
  endtask

  // Drives one request from IDLE, scrambles inputs while in flight, and reports what was observed.
  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [63:0] wd,
                       output int lat, output logic [31:0] data, output int busy_n, output int rsp_cyc);
    int guard = 0;
    while (busy && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    lat = 0; data = 'x; busy_n = 0; rsp_cyc = -1;
    for (int k = 1; k <= 20; k++) begin
      if (busy) busy_n++;
      if (resp_ready) begin
        lat = k; data = resp_data; rsp_cyc = cyc;
        break;
      end
      req_addr  = $urandom;
      req_wdata = {$urandom, $urandom};
      req_op    = ($urandom % 2) ? 2'b10 : 2'b01;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_op = 2'b00;
  endtask

  task automatic txn_check(input string name, input logic [1:0] op, input logic [31:0] addr,
                           input logic [63:0] wd, output int rsp_cyc);
    int lat, busy_n;
    logic [31:0] data, exp;
    exp = model_expect(op, addr);
    issue(op, addr, wd, lat, data, busy_n, rsp_cyc);
    model_apply(op, addr, wd);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, LAT); end
    checks++;
    if (busy_n !== LAT) begin errors++; $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, LAT); end
    checks++;
    if (data !== exp) begin errors++; $display("FAIL %s data addr=%h: got %h want %h", name, addr, data, exp); end
  endtask

  task automatic test_reset;
    int lat = 0;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 32'h0; req_wdata = 64'h0;
    req_valid1 = 1'b0; req_op1 = 2'b00; req_addr1 = 32'h0; req_wdata1 = 64'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = 2'b10; req_addr = 32'h10;
      checks++;
      if ({busy, resp_ready, resp_data} !== 34'h0) begin
        errors++; $display("FAIL reset_outputs: got busy=%b ready=%b data=%h want 0 0 0", busy, resp_ready, resp_data);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL first_accept busy: got %b want 1", busy); end
    for (int k = 1; k <= 20; k++) begin
      if (resp_ready) begin lat = k; break; end
      if (busy !== 1'b1) begin errors++; checks++; $display("FAIL busy_in_flight k=%0d: got 0 want 1", k); end
      @(posedge clk); #1;
    end
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL first_read latency: got %0d want %0d", lat, LAT); end
    checks++;
    if (resp_data !== 32'h0) begin errors++; $display("FAIL first_read data: got %h want 0", resp_data); end
    req_valid = 1'b0; req_op = 2'b00;
    @(posedge clk); #1;
    checks++;
    if ({busy, resp_ready} !== 2'b00) begin errors++; $display("FAIL after_resp idle: got busy=%b ready=%b want 0 0", busy, resp_ready); end
  endtask

  task automatic test_write_read;
    int rc;
    txn_check("wr20", 2'b01, 32'h20, 64'hDEADBEEF_12345678, rc);
    txn_check("rd20", 2'b10, 32'h20, 64'h0, rc);
    txn_check("rd24", 2'b10, 32'h24, 64'h0, rc);
    txn_check("wr27", 2'b01, 32'h27, 64'hCAFEF00D_0BADC0DE, rc);
    txn_check("rd20b", 2'b10, 32'h20, 64'h0, rc);
  endtask

  task automatic test_wrap;
    int rc;
    txn_check("wr1008", 2'b01, 32'h0000_1008, 64'hA5A5A5A5_5A5A5A5A, rc);
    txn_check("rd0008", 2'b10, 32'h0000_0008, 64'h0, rc);
    txn_check("rdF000000C", 2'b10, 32'hF000_000C, 64'h0, rc);
  endtask

  task automatic test_reset_abort;
    int rc;
    int seen = 0;
    req_valid = 1'b1; req_op = 2'b01; req_addr = 32'h40; req_wdata = 64'h11112222_33334444;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy, resp_ready} !== 2'b00) begin errors++; $display("FAIL abort_reset: got busy=%b ready=%b want 0 0", busy, resp_ready); end
    for (int i = 0; i < 8; i++) begin
      if (resp_ready) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_resp: got %0d strobes want 0", seen); end
    txn_check("rd40_after_abort", 2'b10, 32'h40, 64'h0, rc);
    txn_check("rd20_survives_reset", 2'b10, 32'h20, 64'h0, rc);
  endtask

  task automatic test_ignore;
    int bad = 0;
    logic [1:0] ops [2];
    ops[0] = 2'b11; ops[1] = 2'b00;
    for (int j = 0; j < 2; j++) begin
      req_valid = 1'b1; req_op = ops[j]; req_addr = $urandom; req_wdata = {$urandom, $urandom};
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        if (busy !== 1'b0 || resp_ready !== 1'b0) bad++;
      end
    end
    req_valid = 1'b0; req_op = 2'b00;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ignore_noop: got %0d busy/ready cycles want 0", bad); end
  endtask

  task automatic test_latency1;
    req_valid1 = 1'b1; req_op1 = 2'b10; req_addr1 = 32'h8;
    @(posedge clk); #1;
    req_valid1 = 1'b0; req_op1 = 2'b00;
    checks++;
    if ({busy1, resp_ready1, resp_data1} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL lat1_read: got busy=%b ready=%b data=%h want 1 1 0", busy1, resp_ready1, resp_data1);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy1, resp_ready1} !== 2'b00) begin errors++; $display("FAIL lat1_idle: got busy=%b ready=%b want 0 0", busy1, resp_ready1); end
    req_valid1 = 1'b1; req_op1 = 2'b01; req_addr1 = 32'h8; req_wdata1 = 64'h87654321_0FEDCBA9;
    @(posedge clk); #1;
    req_valid1 = 1'b0; req_op1 = 2'b00;
    checks++;
    if ({resp_ready1, resp_data1} !== {1'b1, 32'h0}) begin errors++; $display("FAIL lat1_write: got ready=%b data=%h want 1 0", resp_ready1, resp_data1); end
    @(posedge clk); #1;
    req_valid1 = 1'b1; req_op1 = 2'b10; req_addr1 = 32'hC;
    @(posedge clk); #1;
    req_valid1 = 1'b0; req_op1 = 2'b00;
    checks++;
    if ({resp_ready1, resp_data1} !== {1'b1, 32'h87654321}) begin
      errors++; $display("FAIL lat1_readback: got ready=%b data=%h want 1 87654321", resp_ready1, resp_data1);
    end
  endtask

  task automatic test_back_to_back;
    int rc, prev;
    logic [1:0] op;
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      op = ($urandom % 2) ? 2'b10 : 2'b01;
      txn_check("b2b", op, 32'($urandom_range(0, 15)) << 2, {$urandom, $urandom}, rc);
      if (prev >= 0) begin
        checks++;
        if (rc - prev !== LAT + 1) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", rc - prev, LAT + 1); end
      end
      prev = rc;
    end
  endtask

  task automatic test_random;
    int rc;
    logic [1:0] op;
    logic [31:0] addr;
    for (int i = 0; i < 30; i++) begin
      op   = ($urandom % 2) ? 2'b10 : 2'b01;
      addr = 32'($urandom_range(0, 31)) << 2 | ($urandom & 32'hFFFF_F003);
      txn_check("rand", op, addr, {$urandom, $urandom}, rc);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    test_reset;
    test_write_read;
    test_wrap;
    test_reset_abort;
    test_ignore;
    test_latency1;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_mem_ctrl.md
MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to response; legal range 1..15.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit storage words; power of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1, request present from the cache controller.
REQ-006 The block SHALL have port req_op, input, 2, operation: 2'b10 word read, 2'b01 line write, others no-op.
REQ-007 The block SHALL have port req_addr, input, 32, byte address.
REQ-008 The block SHALL have port req_wdata, input, 64, line write data: [63:32] to the upper word, [31:0] to the lower word.
REQ-009 The block SHALL have port resp_data, output, 32, read data.
REQ-010 The block SHALL have port resp_ready, output, 1, one-cycle completion strobe.
REQ-011 The block SHALL have port busy, output, 1, high while a request is in flight.

Function
REQ-012 Storage SHALL be DEPTH_WORDS x 32-bit words, indexed by word_idx = req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4 bytes.
REQ-013 State machine SHALL have three states: IDLE, WAIT and RESP.
REQ-014 In IDLE with req_valid=1 and req_op in {2'b10, 2'b01}, the block SHALL accept on that edge (cycle T), capture req_addr, req_op and req_wdata, and go to WAIT if LATENCY>1, else to RESP.
REQ-015 In IDLE, req_valid=1 with req_op in {2'b00, 2'b11} SHALL be ignored: no capture, no response, state stays IDLE.
REQ-016 In WAIT, a down-counter loaded at acceptance SHALL advance so that RESP is entered exactly at cycle T+LATENCY; the counter is 4 bits wide.
REQ-017 In RESP (cycle T+LATENCY), resp_ready SHALL be 1 for exactly that one cycle, and the next state is IDLE unconditionally.
REQ-018 For a read, resp_data in RESP SHALL be the stored word at the captured word_idx.
REQ-019 For a write, resp_data in RESP SHALL be 0.
REQ-020 Outside RESP, resp_data SHALL be 0 and resp_ready SHALL be 0.
REQ-021 A line write SHALL commit on the RESP edge: word (word_idx & ~1) <= wdata[31:0] and word (word_idx | 1) <= wdata[63:32]; captured addr[2:0] is ignored.
REQ-022 busy SHALL be 1 in WAIT and RESP, and 0 in IDLE.
REQ-023 Requests presented while busy=1 SHALL be ignored and not queued; the requester holds req_valid until it sees resp_ready.
REQ-024 The earliest next acceptance after a response at cycle R SHALL be cycle R+1, so back-to-back requests complete every LATENCY+1 cycles.
REQ-025 Input changes after acceptance SHALL NOT affect the in-flight operation; captured values are used.
REQ-026 A read after a write to the same word SHALL return the written data, because the write commits before IDLE.

Reset
REQ-027 While rst=1, on each clock edge: state <= IDLE, counter <= 0, resp_ready = 0, resp_data = 0, busy = 0.
REQ-028 Reset mid-operation SHALL abort the operation: a pending write is not committed, and no resp_ready is produced for it.
REQ-029 Reset SHALL NOT clear storage; all words SHALL be 0 at simulation start.
REQ-030 The first request SHALL be accepted in the first cycle with rst=0.

Verification
REQ-031 LATENCY=4: read addr 0x10 accepted at T -> busy=1 for T+1..T+4, resp_ready=1 only at T+4, resp_data=0x00000000.
REQ-032 Write addr 0x20, wdata 0xDEADBEEF_12345678, then read 0x20 and read 0x24 -> 0x12345678 and 0xDEADBEEF respectively, each LATENCY cycles after its acceptance.
REQ-033 DEPTH_WORDS=1024: write to 0x0000_1008, then read 0x0000_0008 -> returns the lower written word (address wrap).
REQ-034 Assert rst at T+2 during a write to 0x40, then read 0x40 -> 0x00000000, and no resp_ready appears for the aborted write.
REQ-035 Request with op=2'b11, then a second request while busy=1 -> no state change and no resp_ready for either; LATENCY=1 read -> resp_ready at T+1.
